// File: rtl/fircoe_load_ctrl.sv
// FIR coefficient load sequencer: issues NUM_BURSTS channel-0 DDR reads for one
// coefficient set and streams the returned words into the coefficient RAM.
// Optional checksum check is enabled by defining FIRCOE_CHKSUM_EN.
module fircoe_load_ctrl #(
  parameter int unsigned NUM_BURSTS      = 4,
  parameter int unsigned WORDS_PER_BURST = 128,
  parameter int unsigned COE_ADDR_WD     = $clog2(NUM_BURSTS * WORDS_PER_BURST),
  parameter logic [31:0] BASE_IDX        = 32'h0,
  parameter logic [31:0] SET_STRIDE      = 32'h40,
  parameter logic [31:0] BURST_STRIDE    = 32'h10,
  parameter int unsigned TIMEOUT_CYC     = 4096
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   load_start,
  input  logic [3:0]             load_set,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic                   err_flag,
`ifdef FIRCOE_CHKSUM_EN
  input  logic [31:0]            chk_expect,
  output logic                   chk_err,
`endif
  output logic                   ddr_rd0_en,
  output logic [31:0]            ddr_rd0_addr,
  input  logic                   readback0_vld,
  input  logic                   readback0_last,
  input  logic [31:0]            readback0_data,
  output logic                   coe_wr_en,
  output logic [COE_ADDR_WD-1:0] coe_wr_addr,
  output logic [31:0]            coe_wr_data
);

  localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned BEAT_W  = (WORDS_PER_BURST > 1) ? $clog2(WORDS_PER_BURST) : 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC);

  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(WORDS_PER_BURST - 1);
  localparam logic [TO_W-1:0]    TO_LIMIT   = TO_W'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           set_q;
  logic [BURST_W-1:0]   burst_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [COE_ADDR_WD-1:0] wr_addr;
  logic [TO_W-1:0]      to_cnt;

  logic word_acc;
  logic burst_end;
  logic timeout_hit;

  // Stream gaps are informational only; bursts end on word count.
  logic unused_last;
  assign unused_last = readback0_last;

  function automatic logic [31:0] req_addr(input logic [3:0] set_idx,
                                           input logic [BURST_W-1:0] burst_idx);
    return BASE_IDX + 32'(set_idx) * SET_STRIDE + 32'(burst_idx) * BURST_STRIDE;
  endfunction

  assign word_acc    = (state == S_WAIT) && readback0_vld;
  assign burst_end   = word_acc && (beat_cnt == LAST_BEAT);
  assign timeout_hit = (state == S_WAIT) && !readback0_vld && (to_cnt == TO_LIMIT);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    ddr_rd0_en = 1'b0;
    load_busy  = 1'b1;
    unique case (state)
      S_IDLE: begin
        load_busy = 1'b0;
        if (load_start) state_nxt = S_REQ;
      end
      S_REQ: begin
        ddr_rd0_en = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (burst_end) begin
          state_nxt = (burst_cnt == LAST_BURST) ? S_DONE : S_REQ;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef FIRCOE_CHKSUM_EN
  logic [31:0] chk_acc;
  logic [31:0] chk_exp_q;
  logic        chk_bad;
  assign chk_bad = (state == S_DONE) && (chk_acc != chk_exp_q);
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      set_q        <= '0;
      burst_cnt    <= '0;
      beat_cnt     <= '0;
      wr_addr      <= '0;
      to_cnt       <= '0;
      err_flag     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      ddr_rd0_addr <= '0;
      coe_wr_en    <= 1'b0;
      coe_wr_addr  <= '0;
      coe_wr_data  <= '0;
`ifdef FIRCOE_CHKSUM_EN
      chk_acc      <= '0;
      chk_exp_q    <= '0;
      chk_err      <= 1'b0;
`endif
    end else begin
      coe_wr_en <= word_acc;
      load_done <= (state == S_DONE);
      load_err  <= (state == S_ERR);
`ifdef FIRCOE_CHKSUM_EN
      chk_err   <= chk_bad;
      if (chk_bad) err_flag <= 1'b1;
`endif

      if (word_acc) begin
        coe_wr_addr <= wr_addr;
        coe_wr_data <= readback0_data;
        wr_addr     <= wr_addr + 1'b1;
        beat_cnt    <= beat_cnt + 1'b1;
        to_cnt      <= '0;
`ifdef FIRCOE_CHKSUM_EN
        chk_acc     <= chk_acc + readback0_data;
`endif
      end else if (state == S_WAIT) begin
        to_cnt <= to_cnt + 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (load_start) begin
            set_q        <= load_set;
            burst_cnt    <= '0;
            beat_cnt     <= '0;
            wr_addr      <= '0;
            err_flag     <= 1'b0;
            ddr_rd0_addr <= req_addr(load_set, '0);
`ifdef FIRCOE_CHKSUM_EN
            chk_acc      <= '0;
            chk_exp_q    <= chk_expect;
`endif
          end
        end
        S_REQ: to_cnt <= '0;
        S_WAIT: begin
          if (burst_end && (burst_cnt != LAST_BURST)) begin
            burst_cnt    <= burst_cnt + 1'b1;
            beat_cnt     <= '0;
            ddr_rd0_addr <= req_addr(set_q, burst_cnt + 1'b1);
          end
        end
        S_ERR:   err_flag <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fircoe_load_ctrl.sv
// Self-checking bench for fircoe_load_ctrl: a DDR responder returns random words
// and a queue-based model checks requests, RAM writes and completion status.
`timescale 1ns/1ps
module tb_fircoe_load_ctrl;

  localparam int NB  = 4;
  localparam int WPB = 128;
  localparam int TOC = 4096;
  localparam int AW  = $clog2(NB * WPB);

  logic          rd_clk;
  logic          rd_rst;
  logic          load_start;
  logic [3:0]    load_set;
  logic          load_busy, load_done, load_err, err_flag;
  logic          ddr_rd0_en;
  logic [31:0]   ddr_rd0_addr;
  logic          readback0_vld, readback0_last;
  logic [31:0]   readback0_data;
  logic          coe_wr_en;
  logic [AW-1:0] coe_wr_addr;
  logic [31:0]   coe_wr_data;
`ifdef FIRCOE_CHKSUM_EN
  logic [31:0]   chk_expect;
  logic          chk_err;
  logic [31:0]   chk_val = 32'h0;
`endif

  fircoe_load_ctrl dut (
    .rd_clk         (rd_clk),
    .rd_rst         (rd_rst),
    .load_start     (load_start),
    .load_set       (load_set),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_err       (load_err),
    .err_flag       (err_flag),
`ifdef FIRCOE_CHKSUM_EN
    .chk_expect     (chk_expect),
    .chk_err        (chk_err),
`endif
    .ddr_rd0_en     (ddr_rd0_en),
    .ddr_rd0_addr   (ddr_rd0_addr),
    .readback0_vld  (readback0_vld),
    .readback0_last (readback0_last),
    .readback0_data (readback0_data),
    .coe_wr_en      (coe_wr_en),
    .coe_wr_addr    (coe_wr_addr),
    .coe_wr_data    (coe_wr_data)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  int cyc = 0;
  always @(posedge rd_clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed traffic and the words the responder actually returned.
  logic [31:0] sent_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int chk_err_cnt = 0, chk_cyc = 0;
  logic busy_at_done = 1'b0;

  always @(negedge rd_clk) begin
    if (coe_wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(coe_wr_addr));
      wr_data_q.push_back(coe_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (ddr_rd0_en === 1'b1) begin
      req_addr_q.push_back(ddr_rd0_addr);
      req_cyc_q.push_back(cyc);
    end
    if (load_done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = load_busy;
    end
    if (load_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
`ifdef FIRCOE_CHKSUM_EN
    if (chk_err === 1'b1) begin
      chk_err_cnt++;
      chk_cyc = cyc;
    end
`endif
  end

  // Responder configuration
  int resp_words[NB];
  int resp_bidx  = 0;
  int gap_burst  = -1;
  int gap_word   = -1;
  int gap_len    = 0;
  bit rand_gaps  = 1'b0;
  bit seq_data   = 1'b0;
  int seq_val    = 0;
  bit resp_busy  = 1'b0;

  initial begin : responder
    int b, n;
    readback0_vld  = 1'b0;
    readback0_last = 1'b0;
    readback0_data = 32'h0;
    @(negedge rd_clk);
    forever begin
      if (ddr_rd0_en === 1'b1) begin
        b = resp_bidx;
        resp_bidx++;
        n = (b < NB) ? resp_words[b] : 0;
        resp_busy = 1'b1;
        repeat (2) @(negedge rd_clk);
        for (int w = 0; w < n; w++) begin
          if (rand_gaps && $urandom_range(0, 7) == 0) begin
            readback0_vld = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge rd_clk);
          end
          seq_val++;
          readback0_vld  = 1'b1;
          readback0_data = seq_data ? 32'(seq_val) : 32'($urandom());
          readback0_last = (b == gap_burst) && (w == gap_word);
          sent_q.push_back(readback0_data);
          @(negedge rd_clk);
          readback0_last = 1'b0;
          if ((b == gap_burst) && (w == gap_word)) begin
            readback0_vld = 1'b0;
            repeat (gap_len) @(negedge rd_clk);
          end
        end
        readback0_vld = 1'b0;
        resp_busy     = 1'b0;
      end else begin
        @(negedge rd_clk);
      end
    end
  end

  function automatic logic [31:0] exp_req_addr(input int s, input int b);
    return 32'(s) * 32'h40 + 32'(b) * 32'h10;
  endfunction

  // Index of the first write that differs from the returned stream, or -1.
  function automatic int first_bad_write();
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (i >= sent_q.size()) return i;
      if (wr_addr_q[i] != i || wr_data_q[i] !== sent_q[i]) return i;
    end
    return -1;
  endfunction

  task automatic resp_default();
    for (int i = 0; i < NB; i++) resp_words[i] = WPB;
    gap_burst = -1;
    gap_word  = -1;
    gap_len   = 0;
    rand_gaps = 1'b0;
    seq_data  = 1'b0;
  endtask

  task automatic start_load(input logic [3:0] s);
    sent_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    req_addr_q.delete();
    req_cyc_q.delete();
    done_cnt = 0; err_cnt = 0; chk_err_cnt = 0;
    resp_bidx = 0; seq_val = 0;
    load_set = s;
`ifdef FIRCOE_CHKSUM_EN
    chk_expect = chk_val;
`endif
    load_start = 1'b1;
    @(negedge rd_clk);
    load_start = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20000 && (done_cnt + err_cnt) == 0; i++) @(negedge rd_clk);
    n_checks++;
    if (done_cnt + err_cnt == 0) begin
      n_fail++;
      $display("FAIL wait_end: no load_done/load_err within 20000 cycles");
    end
    for (int i = 0; i < 2000 && resp_busy; i++) @(negedge rd_clk);
    repeat (4) @(negedge rd_clk);
  endtask

  task automatic test_reset();
    rd_rst = 1'b1;
    repeat (3) @(negedge rd_clk);
    n_checks++;
    if ({load_busy, load_done, load_err, err_flag, ddr_rd0_en, coe_wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {load_busy, load_done, load_err, err_flag, ddr_rd0_en, coe_wr_en});
    end
    n_checks++;
    if (ddr_rd0_addr !== 32'h0 || coe_wr_addr !== '0 || coe_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rd_addr=%h wr_addr=%h wr_data=%h want 0",
               ddr_rd0_addr, coe_wr_addr, coe_wr_data);
    end
    rd_rst = 1'b0;
    repeat (2) @(negedge rd_clk);
    n_checks++;
    if (load_busy !== 1'b0 || ddr_rd0_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b en=%b want 0 0", load_busy, ddr_rd0_en);
    end
  endtask

  task automatic test_normal_load();
    int s, bad, lw;
    for (int it = 0; it < 3; it++) begin
      resp_default();
      s = (it == 0) ? 2 : int'($urandom_range(0, 15));
      rand_gaps = (it != 0);
      start_load(4'(s));
      wait_end();
      n_checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
        n_fail++;
        $display("FAIL normal_status set=%0d: done=%0d err=%0d want 1 0", s, done_cnt, err_cnt);
      end
      n_checks++;
      if (req_addr_q.size() != NB) begin
        n_fail++;
        $display("FAIL normal_req_cnt set=%0d: got %0d want %0d", s, req_addr_q.size(), NB);
      end
      for (int b = 0; b < NB && b < req_addr_q.size(); b++) begin
        n_checks++;
        if (req_addr_q[b] !== exp_req_addr(s, b)) begin
          n_fail++;
          $display("FAIL normal_req_addr set=%0d burst=%0d: got %h want %h",
                   s, b, req_addr_q[b], exp_req_addr(s, b));
        end
      end
      n_checks++;
      if (wr_addr_q.size() != NB * WPB) begin
        n_fail++;
        $display("FAIL normal_wr_cnt set=%0d: got %0d want %0d", s, wr_addr_q.size(), NB * WPB);
      end
      bad = first_bad_write();
      n_checks++;
      if (bad != -1) begin
        n_fail++;
        $display("FAIL normal_wr_data set=%0d: first bad write %0d (addr %0d) want addr %0d data %h",
                 s, bad, wr_addr_q[bad], bad, (bad < sent_q.size()) ? sent_q[bad] : 32'h0);
      end
      lw = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : -100;
      n_checks++;
      if (done_cyc != lw + 1) begin
        n_fail++;
        $display("FAIL normal_done_lat: done at %0d, last write at %0d, want +1", done_cyc, lw);
      end
      n_checks++;
      if (busy_at_done !== 1'b0 || err_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL normal_busy_flag: busy_at_done=%b err_flag=%b want 0 0", busy_at_done, err_flag);
      end
    end
  endtask

  task automatic test_mid_last();
    resp_default();
    gap_burst = 0; gap_word = 39; gap_len = 20;
    start_load(4'd5);
    wait_end();
    n_checks++;
    if (done_cnt != 1 || err_cnt != 0 || req_addr_q.size() != NB) begin
      n_fail++;
      $display("FAIL last_status: done=%0d err=%0d reqs=%0d want 1 0 %0d",
               done_cnt, err_cnt, req_addr_q.size(), NB);
    end
    n_checks++;
    if (wr_cyc_q.size() != NB * WPB || req_cyc_q.size() < 2 || req_cyc_q[1] < wr_cyc_q[WPB - 1]
        || wr_cyc_q[40] - wr_cyc_q[39] < 21) begin
      n_fail++;
      $display("FAIL last_burst_end: writes=%0d reqs=%0d want second request after write %0d and a 20-cycle gap",
               wr_cyc_q.size(), req_cyc_q.size(), WPB - 1);
    end
    n_checks++;
    if (first_bad_write() != -1) begin
      n_fail++;
      $display("FAIL last_wr_data: first bad write %0d want -1", first_bad_write());
    end
  endtask

  task automatic test_timeout();
    int lw, s;
    resp_default();
    resp_words[1] = 100;
    start_load(4'd1);
    wait_end();
    n_checks++;
    if (err_cnt != 1 || done_cnt != 0 || req_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL timeout_status: err=%0d done=%0d reqs=%0d want 1 0 2",
               err_cnt, done_cnt, req_addr_q.size());
    end
    n_checks++;
    if (wr_addr_q.size() != WPB + 100 || first_bad_write() != -1) begin
      n_fail++;
      $display("FAIL timeout_writes: got %0d writes (first bad %0d) want %0d clean",
               wr_addr_q.size(), first_bad_write(), WPB + 100);
    end
    lw = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : 0;
    n_checks++;
    if (err_cyc - lw != TOC) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", err_cyc - lw, TOC);
    end
    n_checks++;
    if (err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flag: err_flag=%b want 1", err_flag);
    end
    resp_default();
    s = int'($urandom_range(0, 15));
    start_load(4'(s));
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flag_clear: err_flag=%b want 0", err_flag);
    end
    wait_end();
    n_checks++;
    if (done_cnt != 1 || wr_addr_q.size() != NB * WPB || first_bad_write() != -1) begin
      n_fail++;
      $display("FAIL timeout_reload: done=%0d writes=%0d want 1 %0d", done_cnt, wr_addr_q.size(), NB * WPB);
    end
  endtask

  task automatic test_start_while_busy();
    int s1, s2, bad_req;
    resp_default();
    rand_gaps = 1'b1;
    s1 = int'($urandom_range(0, 7));
    s2 = s1 + 8;
    start_load(4'(s1));
    for (int i = 0; i < 2000 && wr_addr_q.size() < 10; i++) @(negedge rd_clk);
    load_set   = 4'(s2);
    load_start = 1'b1;
    @(negedge rd_clk);
    load_start = 1'b0;
    wait_end();
    repeat (200) @(negedge rd_clk);
    bad_req = 0;
    for (int b = 0; b < req_addr_q.size(); b++)
      if (b >= NB || req_addr_q[b] !== exp_req_addr(s1, b)) bad_req++;
    n_checks++;
    if (req_addr_q.size() != NB || bad_req != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_start: reqs=%0d bad_addr=%0d done=%0d want %0d 0 1",
               req_addr_q.size(), bad_req, done_cnt, NB);
    end
    n_checks++;
    if (wr_addr_q.size() != NB * WPB || first_bad_write() != -1) begin
      n_fail++;
      $display("FAIL busy_writes: writes=%0d first bad %0d want %0d clean",
               wr_addr_q.size(), first_bad_write(), NB * WPB);
    end
  endtask

  task automatic test_reset_mid();
    int n_wr, s;
    resp_default();
    start_load(4'd9);
    for (int i = 0; i < 3000 && !(req_addr_q.size() == 3 && wr_addr_q.size() >= 2 * WPB + 20); i++)
      @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    n_checks++;
    if ({load_busy, load_done, load_err, err_flag, ddr_rd0_en, coe_wr_en} !== 6'b0
        || ddr_rd0_addr !== 32'h0 || coe_wr_addr !== '0 || coe_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: ctrl=%b rd_addr=%h wr_addr=%h wr_data=%h want all 0",
               {load_busy, load_done, load_err, err_flag, ddr_rd0_en, coe_wr_en},
               ddr_rd0_addr, coe_wr_addr, coe_wr_data);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    n_wr = wr_addr_q.size();
    n_checks++;
    if (resp_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_tail: responder idle at reset release, want burst 2 still in flight");
    end
    for (int i = 0; i < 2000 && resp_busy; i++) @(negedge rd_clk);
    repeat (10) @(negedge rd_clk);
    n_checks++;
    if (wr_addr_q.size() != n_wr || req_addr_q.size() != 3) begin
      n_fail++;
      $display("FAIL rstmid_late_words: writes %0d->%0d reqs=%0d want no change, 3 reqs",
               n_wr, wr_addr_q.size(), req_addr_q.size());
    end
    s = int'($urandom_range(0, 15));
    start_load(4'(s));
    wait_end();
    n_checks++;
    if (req_addr_q.size() != NB || req_addr_q[0] !== exp_req_addr(s, 0) || done_cnt != 1) begin
      n_fail++;
      $display("FAIL rstmid_restart: reqs=%0d first=%h done=%0d want %0d %h 1",
               req_addr_q.size(), (req_addr_q.size() > 0) ? req_addr_q[0] : 32'h0,
               done_cnt, NB, exp_req_addr(s, 0));
    end
    n_checks++;
    if (wr_addr_q.size() != NB * WPB || first_bad_write() != -1) begin
      n_fail++;
      $display("FAIL rstmid_writes: writes=%0d first bad %0d want %0d clean",
               wr_addr_q.size(), first_bad_write(), NB * WPB);
    end
  endtask

`ifdef FIRCOE_CHKSUM_EN
  task automatic test_chksum();
    resp_default();
    seq_data = 1'b1;
    chk_val  = 32'h0002_0100;
    start_load(4'd0);
    wait_end();
    n_checks++;
    if (done_cnt != 1 || chk_err_cnt != 0 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_match: done=%0d chk_err=%0d err_flag=%b want 1 0 0",
               done_cnt, chk_err_cnt, err_flag);
    end
    chk_val = 32'h0;
    start_load(4'd0);
    wait_end();
    n_checks++;
    if (done_cnt != 1 || chk_err_cnt != 1 || chk_cyc != done_cyc || err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL chk_mismatch: done=%0d chk_err=%0d chk_cyc=%0d done_cyc=%0d err_flag=%b want 1 1 equal 1",
               done_cnt, chk_err_cnt, chk_cyc, done_cyc, err_flag);
    end
  endtask
`endif

  initial begin
    rd_rst     = 1'b1;
    load_start = 1'b0;
    load_set   = 4'd0;
`ifdef FIRCOE_CHKSUM_EN
    chk_expect = 32'h0;
`endif
    resp_default();
    @(negedge rd_clk);
    test_reset();
    test_normal_load();
    test_mid_last();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
`ifdef FIRCOE_CHKSUM_EN
    test_chksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
